// File: rtl/reduction_signed_window_stats.sv
// Windowed statistics over signed/unsigned byte pairs: saturating signed sum, predicate counts and sticky flags.
// Report valid the cycle after the WINDOW-th accept; in_ready only in ACCUM, report held until out_ready.
module reduction_signed_window_stats #(
  parameter int WINDOW = 8,
  parameter int SUM_W  = 12,
  localparam int CNT_W = $clog2(WINDOW + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [7:0]              signed_val,
  input  logic [7:0]              unsigned_val,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [SUM_W-1:0] sum_out,
  output logic [CNT_W-1:0]        neg_count,
  output logic [CNT_W-1:0]        allones_count,
  output logic [CNT_W-1:0]        both_count,
  output logic                    any_nonzero,
  output logic                    saturated,
  output logic                    busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_REPORT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WINDOW - 1);

  state_t                  r_state;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;
  logic                    r_any_nonzero;
  logic                    r_saturated;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        r_neg;
  logic [CNT_W-1:0]        r_allones;
  logic [CNT_W-1:0]        r_both;
  logic signed [SUM_W-1:0] r_sum;

  logic                    w_accept;
  logic                    w_is_neg;
  logic                    w_all_ones;
  logic                    w_ovf;
  logic signed [SUM_W:0]   w_ext;
  logic signed [SUM_W:0]   w_wide;
  logic signed [SUM_W-1:0] w_sum_next;

  assign w_accept   = in_valid & r_in_ready;
  assign w_is_neg   = signed_val[7];
  assign w_all_ones = &unsigned_val;

  // One guard bit is enough: the two top bits disagree exactly when the result left the SUM_W range.
  assign w_ext      = {{(SUM_W - 7){signed_val[7]}}, signed_val};
  assign w_wide     = {r_sum[SUM_W-1], r_sum} + w_ext;
  assign w_ovf      = w_wide[SUM_W] ^ w_wide[SUM_W-1];
  assign w_sum_next = !w_ovf        ? w_wide[SUM_W-1:0] :
                      w_wide[SUM_W] ? {1'b1, {(SUM_W - 1){1'b0}}} :
                                      {1'b0, {(SUM_W - 1){1'b1}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_any_nonzero <= 1'b0;
      r_saturated   <= 1'b0;
      r_cnt         <= '0;
      r_neg         <= '0;
      r_allones     <= '0;
      r_both        <= '0;
      r_sum         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state       <= S_ACCUM;
            r_in_ready    <= 1'b1;
            r_busy        <= 1'b1;
            r_any_nonzero <= 1'b0;
            r_saturated   <= 1'b0;
            r_cnt         <= '0;
            r_neg         <= '0;
            r_allones     <= '0;
            r_both        <= '0;
            r_sum         <= '0;
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_sum         <= w_sum_next;
            r_saturated   <= r_saturated | w_ovf;
            r_any_nonzero <= r_any_nonzero | (|signed_val);
            r_neg         <= r_neg + CNT_W'(w_is_neg);
            r_allones     <= r_allones + CNT_W'(w_all_ones);
            r_both        <= r_both + CNT_W'(w_is_neg & w_all_ones);
            r_cnt         <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_IDX) begin
              r_state     <= S_REPORT;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready      = r_in_ready;
  assign out_valid     = r_out_valid;
  assign busy          = r_busy;
  assign sum_out       = r_sum;
  assign neg_count     = r_neg;
  assign allones_count = r_allones;
  assign both_count    = r_both;
  assign any_nonzero   = r_any_nonzero;
  assign saturated     = r_saturated;

endmodule
